// File: rtl/gated_pulse_counter_if.sv
// Bus between the pulse counter and its consumer: enable/pulse in, published count out.
interface gated_pulse_counter_if #(
    parameter int unsigned WIDTH = 7
);
    logic             en;
    logic             pulse_in;
    logic [WIDTH-1:0] validCount;
    logic             valid_stb;
    logic             overflow;

    modport master (
        output en,
        output pulse_in,
        input  validCount,
        input  valid_stb,
        input  overflow
    );

    modport slave (
        input  en,
        input  pulse_in,
        output validCount,
        output valid_stb,
        output overflow
    );
endinterface

// File: rtl/gated_pulse_counter.sv
// Counts synchronized rising edges of pulse_in over fixed gate windows and publishes
// each window's (saturating) count atomically with a one-cycle strobe.
module gated_pulse_counter #(
    parameter int unsigned WIDTH       = 7,
    parameter int unsigned GATE_CYCLES = 1000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gated_pulse_counter_if.slave  bus
);

    localparam int unsigned GateW = $clog2(GATE_CYCLES);
    localparam int unsigned ArmW  = $clog2(SYNC_STAGES + 1);
    // Timer also paces ARM, so it must be wide enough for either use.
    localparam int unsigned TmrW  = (GateW > ArmW) ? GateW : ArmW;

    localparam logic [TmrW-1:0]  TmrLast = TmrW'(GATE_CYCLES - 1);
    localparam logic [TmrW-1:0]  ArmLast = TmrW'(SYNC_STAGES);
    localparam logic [WIDTH-1:0] CntMax  = '1;

    typedef enum logic [1:0] {StIdle, StArm, StCount} state_e;

    state_e                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic [WIDTH-1:0]       r_cnt;
    logic [TmrW-1:0]        r_tmr;
    logic                   r_ovf_w;
    logic [WIDTH-1:0]       r_valid_count;
    logic                   r_valid_stb;
    logic                   r_overflow;

    logic                   w_rise;
    logic                   w_cnt_max;
    logic [WIDTH-1:0]       w_cnt_next;
    logic                   w_ovf_next;

    assign w_rise     = r_sync[SYNC_STAGES-1] & ~r_hist;
    assign w_cnt_max  = (r_cnt == CntMax);
    assign w_cnt_next = (w_rise && !w_cnt_max) ? r_cnt + WIDTH'(1) : r_cnt;
    assign w_ovf_next = r_ovf_w | (w_rise & w_cnt_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_sync        <= '0;
            r_hist        <= 1'b0;
            r_cnt         <= '0;
            r_tmr         <= '0;
            r_ovf_w       <= 1'b0;
            r_valid_count <= '0;
            r_valid_stb   <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], bus.pulse_in};
            r_hist      <= r_sync[SYNC_STAGES-1];
            r_valid_stb <= 1'b0;
            if (!bus.en) begin
                // Disable discards the partial window; published outputs hold.
                r_state <= StIdle;
                r_cnt   <= '0;
                r_tmr   <= '0;
                r_ovf_w <= 1'b0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        r_state <= StArm;
                        r_cnt   <= '0;
                        r_tmr   <= '0;
                        r_ovf_w <= 1'b0;
                    end
                    StArm: begin
                        if (r_tmr == ArmLast) begin
                            r_state <= StCount;
                            r_tmr   <= '0;
                            r_cnt   <= '0;
                            r_ovf_w <= 1'b0;
                        end else begin
                            r_tmr <= r_tmr + TmrW'(1);
                        end
                    end
                    StCount: begin
                        if (r_tmr == TmrLast) begin
                            // A rise in the terminal cycle belongs to the closing window.
                            r_valid_count <= w_cnt_next;
                            r_overflow    <= w_ovf_next;
                            r_valid_stb   <= 1'b1;
                            r_cnt         <= '0;
                            r_tmr         <= '0;
                            r_ovf_w       <= 1'b0;
                        end else begin
                            r_cnt   <= w_cnt_next;
                            r_ovf_w <= w_ovf_next;
                            r_tmr   <= r_tmr + TmrW'(1);
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign bus.validCount = r_valid_count;
    assign bus.valid_stb  = r_valid_stb;
    assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_gated_pulse_counter.sv
// Directed bench: DUT A (100-cycle gate) for counting/boundary/disable/reset,
// DUT B (500-cycle gate) for saturation. Both share clk, rst_n and pulse_in.
module tb_gated_pulse_counter;

    localparam int unsigned W  = 7;
    localparam int unsigned GA = 100;
    localparam int unsigned GB = 500;
    localparam int unsigned SS = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic en_a  = 1'b0;
    logic en_b  = 1'b0;
    logic pulse = 1'b0;

    always #5 clk = ~clk;

    gated_pulse_counter_if #(.WIDTH(W)) bus_a ();
    gated_pulse_counter_if #(.WIDTH(W)) bus_b ();

    assign bus_a.en       = en_a;
    assign bus_a.pulse_in = pulse;
    assign bus_b.en       = en_b;
    assign bus_b.pulse_in = pulse;

    gated_pulse_counter #(.WIDTH(W), .GATE_CYCLES(GA), .SYNC_STAGES(SS)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    gated_pulse_counter #(.WIDTH(W), .GATE_CYCLES(GB), .SYNC_STAGES(SS)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    typedef struct {
        int sel;
        int pulses;
        int exp_cnt;
        bit exp_ovf;
    } vec_t;

    vec_t vecs [9];

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [W-1:0] prev_cnt;
    logic       prev_ovf;
    bit         hold_bad;

    function automatic logic [W-1:0] cnt_of(int sel);
        return (sel != 0) ? bus_b.validCount : bus_a.validCount;
    endfunction

    function automatic logic stb_of(int sel);
        return (sel != 0) ? bus_b.valid_stb : bus_a.valid_stb;
    endfunction

    function automatic logic ovf_of(int sel);
        return (sel != 0) ? bus_b.overflow : bus_a.overflow;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic sync_prev(input int sel);
        prev_cnt = cnt_of(sel);
        prev_ovf = ovf_of(sel);
    endtask

    // One clock, sampled 1 time unit after the edge; flags output changes without a strobe.
    task automatic step(input int sel);
        @(posedge clk);
        #1;
        if (!stb_of(sel) && (cnt_of(sel) !== prev_cnt || ovf_of(sel) !== prev_ovf))
            hold_bad = 1'b1;
        sync_prev(sel);
    endtask

    task automatic pulses(input int sel, input int k);
        for (int i = 0; i < k; i++) begin
            pulse = 1'b1;
            step(sel);
            if (stb_of(sel)) hold_bad = 1'b1;
            pulse = 1'b0;
            step(sel);
            if (stb_of(sel)) hold_bad = 1'b1;
        end
    endtask

    task automatic wait_stb(input int sel, input int bound, output int cycles);
        cycles = 0;
        do begin
            step(sel);
            cycles++;
        end while (!stb_of(sel) && cycles < bound);
        if (!stb_of(sel)) begin
            n_tests++;
            n_fail++;
            $display("FAIL strobe_timeout: no valid_stb within %0d cycles (dut %0d)", bound, sel);
        end
    endtask

    // Starts in the first cycle of a window, ends on the cycle its strobe is visible.
    task automatic run_vec(input int i);
        int c;
        int gate;
        gate     = (vecs[i].sel != 0) ? GB : GA;
        hold_bad = 1'b0;
        pulses(vecs[i].sel, vecs[i].pulses);
        wait_stb(vecs[i].sel, 2 * gate, c);
        check($sformatf("vec%0d_period", i), 2 * vecs[i].pulses + c, gate);
        check($sformatf("vec%0d_count", i), int'(cnt_of(vecs[i].sel)), vecs[i].exp_cnt);
        check($sformatf("vec%0d_overflow", i), int'(ovf_of(vecs[i].sel)), int'(vecs[i].exp_ovf));
        check($sformatf("vec%0d_hold", i), int'(hold_bad), 0);
    endtask

    initial begin
        int c;

        vecs[0] = '{0, 37, 37, 1'b0};
        vecs[1] = '{0, 0, 0, 1'b0};
        vecs[2] = '{0, 1, 1, 1'b0};
        vecs[3] = '{0, 49, 49, 1'b0};
        vecs[4] = '{0, 12, 12, 1'b0};
        vecs[5] = '{1, 200, 127, 1'b1};
        vecs[6] = '{1, 5, 5, 1'b0};
        vecs[7] = '{1, 127, 127, 1'b0};
        vecs[8] = '{1, 128, 127, 1'b1};

        #1 rst_n = 1'b0;
        #11;
        check("reset_count", int'(bus_a.validCount), 0);
        check("reset_stb", int'(bus_a.valid_stb), 0);
        check("reset_overflow", int'(bus_a.overflow), 0);
        check("reset_count_b", int'(bus_b.validCount), 0);

        // First window after enable: ARM (3 cycles) + 100 counting cycles.
        @(negedge clk);
        rst_n = 1'b1;
        en_a  = 1'b1;
        sync_prev(0);
        wait_stb(0, 300, c);
        check("first_latency", c, GA + SS + 2);
        check("first_count", int'(bus_a.validCount), 0);

        for (int i = 0; i < 5; i++) run_vec(i);

        // Rise in the terminal cycle, then one early in the next window.
        repeat (97) step(0);
        pulse = 1'b1; step(0);
        pulse = 1'b0; step(0);
        pulse = 1'b1; step(0);
        check("bnd_term_stb", int'(bus_a.valid_stb), 1);
        check("bnd_term_count", int'(bus_a.validCount), 1);
        pulse = 1'b0;
        wait_stb(0, 200, c);
        check("bnd_next_period", c, GA);
        check("bnd_next_count", int'(bus_a.validCount), 1);

        // Rise late in one window, then a rise landing on the first cycle of the next.
        repeat (96) step(0);
        pulse = 1'b1; step(0);
        pulse = 1'b0; step(0);
        pulse = 1'b1; step(0);
        pulse = 1'b0; step(0);
        check("bnd2_stb", int'(bus_a.valid_stb), 1);
        check("bnd2_count", int'(bus_a.validCount), 1);
        wait_stb(0, 200, c);
        check("bnd2_first_cycle_count", int'(bus_a.validCount), 1);

        // Disable in the terminal cycle: nothing is published.
        pulses(0, 5);
        repeat (89) step(0);
        en_a = 1'b0;
        step(0);
        check("term_dis_stb", int'(bus_a.valid_stb), 0);
        check("term_dis_count", int'(bus_a.validCount), 1);

        // Re-enable with an edge during ARM (ignored) and 4 in the window.
        en_a  = 1'b1;
        pulse = 1'b1;
        step(0);
        pulse = 1'b0;
        repeat (3) step(0);
        pulses(0, 4);
        wait_stb(0, 300, c);
        check("arm_latency", 4 + 8 + c, GA + SS + 2);
        check("arm_count", int'(bus_a.validCount), 4);

        // Disable mid-window, then watch for any strobe or output change.
        pulses(0, 10);
        repeat (30) step(0);
        en_a = 1'b0;
        step(0);
        hold_bad = 1'b0;
        repeat (150) begin
            step(0);
            if (bus_a.valid_stb) hold_bad = 1'b1;
        end
        check("mid_dis_quiet", int'(hold_bad), 0);
        check("mid_dis_count", int'(bus_a.validCount), 4);

        // Saturation on the 500-cycle gate.
        en_b = 1'b1;
        sync_prev(1);
        wait_stb(1, 1100, c);
        check("b_first_latency", c, GB + SS + 2);
        check("b_first_count", int'(bus_b.validCount), 0);
        for (int i = 5; i < 9; i++) run_vec(i);
        en_b = 1'b0;

        // Asynchronous reset mid-window, with pulse_in then held high.
        en_a = 1'b1;
        step(0);
        repeat (10) step(0);
        pulses(0, 20);
        #2;
        rst_n = 1'b0;
        pulse = 1'b1;
        #1;
        check("rst_mid_count", int'(bus_a.validCount), 0);
        check("rst_mid_stb", int'(bus_a.valid_stb), 0);
        check("rst_mid_overflow", int'(bus_a.overflow), 0);
        check("rst_mid_overflow_b", int'(bus_b.overflow), 0);
        check("rst_mid_count_b", int'(bus_b.validCount), 0);
        @(negedge clk);
        rst_n = 1'b1;
        sync_prev(0);
        wait_stb(0, 300, c);
        check("rel_latency", c, GA + SS + 2);
        check("held_count_1", int'(bus_a.validCount), 0);
        wait_stb(0, 300, c);
        check("held_count_2", int'(bus_a.validCount), 0);
        pulse = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
